// File: rtl/game_io_capture.sv
// Per-frame capture of paddle timing and sprite collisions, published at vsync
// and read by the CPU through an 8-byte memory-mapped window.
module game_io_capture #(
    parameter logic [7:0] BASE      = 8'h40,
    parameter logic [7:0] NO_PADDLE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hpaddle,
    input  logic       vpaddle,
    input  logic       player_gfx,
    input  logic       enemy_gfx,
    input  logic       track_gfx,
    input  logic [7:0] address,
    input  logic       write,
    input  logic [7:0] data_in,
    output logic       hit,
    output logic [7:0] data_out
);

    logic       hp_s1_q, hp_s1_d, hp_s2_q, hp_s2_d, hp_s3_q, hp_s3_d;
    logic       vp_s1_q, vp_s1_d, vp_s2_q, vp_s2_d, vp_s3_q, vp_s3_d;
    logic       vsync_q, vsync_d;
    logic       armed_x_q, armed_x_d, armed_y_q, armed_y_d;
    logic [7:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d;
    logic [7:0] paddle_x_q, paddle_x_d, paddle_y_q, paddle_y_d;
    logic       acc_pe_q, acc_pe_d, acc_pt_q, acc_pt_d;
    logic       pub_pe_q, pub_pe_d, pub_pt_q, pub_pt_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       frame_ready_q, frame_ready_d;

    logic vs_rise, hp_rise, vp_rise, ack, pix_pe, pix_pt;
    logic unused_ok;

    assign unused_ok = ^{hpos[8], vpos[8], data_in};
    assign hit       = (address[7:3] == BASE[7:3]);
    assign ack       = write & hit & (address[2:0] == 3'd7);
    assign vs_rise   = vsync & ~vsync_q;
    assign hp_rise   = hp_s2_q & ~hp_s3_q;
    assign vp_rise   = vp_s2_q & ~vp_s3_q;
    assign pix_pe    = player_gfx & enemy_gfx;
    assign pix_pt    = player_gfx & track_gfx;

    always_comb begin
        hp_s1_d       = hpaddle;
        hp_s2_d       = hp_s1_q;
        hp_s3_d       = hp_s2_q;
        vp_s1_d       = vpaddle;
        vp_s2_d       = vp_s1_q;
        vp_s3_d       = vp_s2_q;
        vsync_d       = vsync;
        armed_x_d     = armed_x_q;
        armed_y_d     = armed_y_q;
        cap_x_d       = cap_x_q;
        cap_y_d       = cap_y_q;
        paddle_x_d    = paddle_x_q;
        paddle_y_d    = paddle_y_q;
        acc_pe_d      = acc_pe_q | pix_pe;
        acc_pt_d      = acc_pt_q | pix_pt;
        pub_pe_d      = pub_pe_q;
        pub_pt_d      = pub_pt_q;
        frame_cnt_d   = frame_cnt_q;
        frame_ready_d = frame_ready_q;

        if (vs_rise) begin
            // Frame boundary: publish, re-arm; a paddle edge in this cycle is dropped.
            paddle_x_d    = armed_x_q ? NO_PADDLE : cap_x_q;
            paddle_y_d    = armed_y_q ? NO_PADDLE : cap_y_q;
            armed_x_d     = 1'b1;
            armed_y_d     = 1'b1;
            cap_x_d       = 8'd0;
            cap_y_d       = 8'd0;
            pub_pe_d      = acc_pe_q | pix_pe;
            pub_pt_d      = acc_pt_q | pix_pt;
            acc_pe_d      = 1'b0;
            acc_pt_d      = 1'b0;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            frame_ready_d = 1'b1;
        end else begin
            if (hp_rise && armed_x_q) begin
                cap_x_d   = vpos[7:0];
                armed_x_d = 1'b0;
            end
            if (vp_rise && armed_y_q) begin
                cap_y_d   = vpos[7:0];
                armed_y_d = 1'b0;
            end
            if (ack) begin
                frame_ready_d = 1'b0;
                pub_pe_d      = 1'b0;
                pub_pt_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hp_s1_q       <= 1'b0;
            hp_s2_q       <= 1'b0;
            hp_s3_q       <= 1'b0;
            vp_s1_q       <= 1'b0;
            vp_s2_q       <= 1'b0;
            vp_s3_q       <= 1'b0;
            vsync_q       <= 1'b0;
            armed_x_q     <= 1'b1;
            armed_y_q     <= 1'b1;
            cap_x_q       <= 8'd0;
            cap_y_q       <= 8'd0;
            paddle_x_q    <= NO_PADDLE;
            paddle_y_q    <= NO_PADDLE;
            acc_pe_q      <= 1'b0;
            acc_pt_q      <= 1'b0;
            pub_pe_q      <= 1'b0;
            pub_pt_q      <= 1'b0;
            frame_cnt_q   <= 8'd0;
            frame_ready_q <= 1'b0;
        end else begin
            hp_s1_q       <= hp_s1_d;
            hp_s2_q       <= hp_s2_d;
            hp_s3_q       <= hp_s3_d;
            vp_s1_q       <= vp_s1_d;
            vp_s2_q       <= vp_s2_d;
            vp_s3_q       <= vp_s3_d;
            vsync_q       <= vsync_d;
            armed_x_q     <= armed_x_d;
            armed_y_q     <= armed_y_d;
            cap_x_q       <= cap_x_d;
            cap_y_q       <= cap_y_d;
            paddle_x_q    <= paddle_x_d;
            paddle_y_q    <= paddle_y_d;
            acc_pe_q      <= acc_pe_d;
            acc_pt_q      <= acc_pt_d;
            pub_pe_q      <= pub_pe_d;
            pub_pt_q      <= pub_pt_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    always_comb begin
        data_out = 8'd0;
        if (hit) begin
            case (address[2:0])
                3'd0:    data_out = hpos[7:0];
                3'd1:    data_out = vpos[7:0];
                3'd2:    data_out = {frame_ready_q, 1'b0, pub_pe_q | pub_pt_q, vsync,
                                     hsync, vp_s2_q, hp_s2_q, display_on};
                3'd3:    data_out = paddle_x_q;
                3'd4:    data_out = paddle_y_q;
                3'd5:    data_out = {6'd0, pub_pt_q, pub_pe_q};
                3'd6:    data_out = frame_cnt_q;
                default: data_out = 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_game_io_capture.sv
// Bench for game_io_capture: frame-level reference model checked every cycle,
// plus directed frames with literal expectations.
module tb_game_io_capture;

    localparam logic [7:0] BASE = 8'h40;

    logic       clk;
    logic       reset;
    logic [8:0] hpos, vpos;
    logic       display_on, hsync, vsync, hpaddle, vpaddle;
    logic       player_gfx, enemy_gfx, track_gfx;
    logic [7:0] address, data_in;
    logic       write;
    logic       hit;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int frames   = 0;

    game_io_capture #(.BASE(BASE), .NO_PADDLE(8'hFF)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .hsync(hsync), .vsync(vsync),
        .hpaddle(hpaddle), .vpaddle(vpaddle), .player_gfx(player_gfx),
        .enemy_gfx(enemy_gfx), .track_gfx(track_gfx), .address(address),
        .write(write), .data_in(data_in), .hit(hit), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-frame "first edge position" (-1 = none) and
    // per-frame collision flags, published at each frame boundary.
    int         m_hcap = -1, m_vcap = -1;
    logic [7:0] m_px = 8'hFF, m_py = 8'hFF, m_cnt = 8'd0;
    logic       m_ready = 0, m_pe = 0, m_pt = 0, m_fpe = 0, m_fpt = 0;
    logic       hh[3], vh[3];
    logic       m_vs_prev = 0;
    logic       t_vsr, t_hr, t_vr, t_ack;

    initial begin
        for (int i = 0; i < 3; i++) begin hh[i] = 0; vh[i] = 0; end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_hcap = -1; m_vcap = -1; m_px = 8'hFF; m_py = 8'hFF; m_cnt = 8'd0;
                m_ready = 0; m_pe = 0; m_pt = 0; m_fpe = 0; m_fpt = 0; m_vs_prev = 0;
                for (int i = 0; i < 3; i++) begin hh[i] = 0; vh[i] = 0; end
            end else begin
                // hh[j] = pin value sampled j+1 clocks ago
                t_vsr = vsync && !m_vs_prev;
                t_hr  = hh[1] && !hh[2];
                t_vr  = vh[1] && !vh[2];
                t_ack = write && (address == BASE + 8'd7);
                m_fpe = m_fpe | (player_gfx & enemy_gfx);
                m_fpt = m_fpt | (player_gfx & track_gfx);
                if (t_vsr) begin
                    m_px = (m_hcap < 0) ? 8'hFF : 8'(m_hcap);
                    m_py = (m_vcap < 0) ? 8'hFF : 8'(m_vcap);
                    m_hcap = -1; m_vcap = -1;
                    m_pe = m_fpe; m_pt = m_fpt; m_fpe = 0; m_fpt = 0;
                    m_ready = 1; m_cnt = m_cnt + 8'd1;
                end else begin
                    if (t_hr && m_hcap < 0) m_hcap = int'(vpos[7:0]);
                    if (t_vr && m_vcap < 0) m_vcap = int'(vpos[7:0]);
                    if (t_ack) begin m_ready = 0; m_pe = 0; m_pt = 0; end
                end
                hh[2] = hh[1]; hh[1] = hh[0]; hh[0] = hpaddle;
                vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = vpaddle;
                m_vs_prev = vsync;
            end
        end
    end

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        logic [7:0] r;
        r = 8'd0;
        if (a[7:3] == BASE[7:3]) begin
            case (a[2:0])
                3'd0: r = hpos[7:0];
                3'd1: r = vpos[7:0];
                3'd2: r = {m_ready, 1'b0, m_pe | m_pt, vsync, hsync, vh[1], hh[1], display_on};
                3'd3: r = m_px;
                3'd4: r = m_py;
                3'd5: r = {6'd0, m_pt, m_pe};
                3'd6: r = m_cnt;
                default: r = 8'd0;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle out of reset, outputs vs model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                check("hit", {7'd0, hit}, {7'd0, address[7:3] == BASE[7:3]});
                check("data_out", data_out, exp_read(address));
            end
        end
    end

    function automatic bit in_pulse(input int i, input int p);
        return (p >= 0) && (i >= p) && (i < p + 4);
    endfunction

    // One frame; vpos = cycle/4, vsync high for the last 4 cycles (rise at len-4).
    task automatic do_frame(input int len, input int hp1, input int hp2, input int vp1,
                            input int pe_at, input int pt_at, input int ack_at,
                            input bit rnd, input int stop_at);
        for (int i = 0; i < len && i < stop_at; i++) begin
            @(negedge clk); #1;
            vpos       = 9'(i >> 2);
            hpos       = 9'($urandom);
            display_on = 1'($urandom);
            hsync      = 1'($urandom);
            vsync      = (i >= len - 4);
            data_in    = 8'($urandom);
            if (rnd) begin
                if ($urandom_range(0, 29) == 0) hpaddle = ~hpaddle;
                if ($urandom_range(0, 29) == 0) vpaddle = ~vpaddle;
                player_gfx = ($urandom_range(0, 31) == 0);
                enemy_gfx  = 1'($urandom);
                track_gfx  = 1'($urandom);
                write      = ($urandom_range(0, 39) == 0);
                address    = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                         : BASE + 8'($urandom_range(0, 7));
            end else begin
                hpaddle    = in_pulse(i, hp1) || in_pulse(i, hp2);
                vpaddle    = in_pulse(i, vp1);
                player_gfx = (i == pe_at) || (i == pt_at);
                enemy_gfx  = (i == pe_at);
                track_gfx  = (i == pt_at);
                write      = (i == ack_at);
                address    = write ? BASE + 8'd7 : BASE + 8'($urandom_range(0, 6));
            end
            if (i == len - 4) frames++;
        end
    endtask

    task automatic lit(input logic [2:0] off, input logic [7:0] mask,
                       input logic [7:0] exp, input string name);
        @(negedge clk); #1;
        address = BASE + 8'(off); write = 1'b0;
        player_gfx = 0; hpaddle = 0; vpaddle = 0;
        @(negedge clk);
        check(name, data_out & mask, exp);
    endtask

    task automatic ack_write();
        @(negedge clk); #1;
        address = BASE + 8'd7; write = 1'b1; player_gfx = 0;
        @(negedge clk); #1;
        write = 1'b0; address = BASE;
    endtask

    initial begin
        reset = 0; hpos = 0; vpos = 0; display_on = 0; hsync = 0; vsync = 0;
        hpaddle = 0; vpaddle = 0; player_gfx = 0; enemy_gfx = 0; track_gfx = 0;
        address = 8'h00; write = 0; data_in = 0;
        repeat (3) @(negedge clk);
        #1 reset = 1;

        lit(3'd3, 8'hFF, 8'hFF, "reset_paddle_x");
        lit(3'd4, 8'hFF, 8'hFF, "reset_paddle_y");
        lit(3'd6, 8'hFF, 8'h00, "reset_frame_cnt");
        lit(3'd2, 8'h80, 8'h00, "reset_frame_ready");

        // Two hpaddle pulses (vpos 100, 150): only the first is kept.
        do_frame(640, 400, 600, -1, -1, -1, -1, 0, 1 << 30);
        lit(3'd3, 8'hFF, 8'd100, "paddle_x_first_edge");
        lit(3'd4, 8'hFF, 8'hFF, "paddle_y_no_edge");
        lit(3'd2, 8'h80, 8'h80, "frame_ready_set");
        lit(3'd6, 8'hFF, 8'h01, "frame_cnt_one");

        do_frame(400, -1, -1, 148, 300, -1, -1, 0, 1 << 30);
        lit(3'd4, 8'hFF, 8'd37, "paddle_y_37");
        lit(3'd3, 8'hFF, 8'hFF, "paddle_x_rearmed");
        lit(3'd5, 8'hFF, 8'h01, "collide_pe");
        ack_write();
        lit(3'd5, 8'hFF, 8'h00, "collide_after_ack");
        lit(3'd2, 8'h80, 8'h00, "frame_ready_after_ack");

        do_frame(200, -1, -1, -1, -1, -1, -1, 0, 1 << 30);
        lit(3'd5, 8'hFF, 8'h00, "collide_quiet_frame");

        // ACK and an overlap pixel both land on the vsync-rise cycle.
        do_frame(200, -1, -1, -1, 196, 120, 196, 0, 1 << 30);
        lit(3'd2, 8'h80, 8'h80, "ready_wins_over_ack");
        lit(3'd5, 8'hFF, 8'h03, "collide_publish_wins");

        for (int f = 0; f < 30; f++)
            do_frame(int'($urandom_range(40, 300)), -1, -1, -1, -1, -1, -1, 1, 1 << 30);

        while (frames < 256)
            do_frame(16, -1, -1, -1, -1, -1, -1, 0, 1 << 30);
        lit(3'd6, 8'hFF, 8'h00, "frame_cnt_wrap");

        // Capture mid-frame, then reset before the frame boundary.
        do_frame(640, 40, -1, -1, -1, -1, -1, 0, 100);
        @(negedge clk); #1 reset = 0;
        #12 reset = 1;
        lit(3'd3, 8'hFF, 8'hFF, "mid_reset_paddle_x");
        lit(3'd6, 8'hFF, 8'h00, "mid_reset_frame_cnt");
        do_frame(200, -1, -1, -1, -1, -1, -1, 0, 1 << 30);
        lit(3'd3, 8'hFF, 8'hFF, "partial_capture_discarded");
        lit(3'd6, 8'hFF, 8'h01, "count_after_reset_frame");

        do_frame(300, -1, -1, -1, -1, -1, -1, 1, 1 << 30);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
